oclib_uart_core: RTL and testbench

OCLIB_UART_CORE -- requirements
Module: oclib_uart_core

---
 rtl/oclib_pkg.sv | 42 ++++
 rtl/oclib_uart_fifo.sv | 73 +++++++
 rtl/oclib_uart_core.sv | 376 +++++++++++++++++++++++++++++++++++++
 tb/tb_oclib_uart_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// oclib_pkg -- shared types and helpers for the oclib UART core.
//   parityModeE  : parity encoding (0 none, 1 odd, 2 even)
//   txStateE     : transmit FSM states
//   rxStateE     : receive FSM states
//   bitCycles()  : clocks per bit, rounded to nearest
//   parityBit()  : parity bit to transmit / expect for a data byte
package oclib_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parityModeE;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } txStateE;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rxStateE;

    // Round-to-nearest integer division of clock rate by line rate.
    function automatic int bitCycles(input int clockHz, input int baud);
        return (clockHz + (baud / 2)) / baud;
    endfunction

    // Unused upper data bits must already be zero so they do not disturb the XOR.
    function automatic logic parityBit(input logic [7:0] data, input parityModeE mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/oclib_uart_fifo.sv
// oclib_uart_fifo -- synchronous FIFO with registered full/empty flags.
//   clock, reset      : clock, asynchronous active-high reset
//   wrEn, wrData      : write request; ignored when full unless a read happens the same clock
//   rdEn, rdData      : read request; rdData shows the head entry (zero after reset)
//   full, empty       : occupancy flags
module oclib_uart_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [Width-1:0] wrData,
    input  logic             rdEn,
    output logic [Width-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int AddrW = $clog2(Depth);

    logic [Width-1:0] mem_r [Depth];
    logic [AddrW-1:0] wrPtr_r;
    logic [AddrW-1:0] rdPtr_r;
    logic [AddrW:0]   count_r;
    logic [AddrW:0]   countNext_s;
    logic             full_r;
    logic             empty_r;
    logic             rdEff_s;
    logic             wrEff_s;

    // Effective read/write and the occupancy they produce; a read frees a slot for a same-clock write.
    always_comb begin
        rdEff_s     = rdEn && !empty_r;
        wrEff_s     = wrEn && (!full_r || rdEff_s);
        countNext_s = count_r;
        case ({wrEff_s, rdEff_s})
            2'b10:   countNext_s = count_r + (AddrW+1)'(1);
            2'b01:   countNext_s = count_r - (AddrW+1)'(1);
            default: countNext_s = count_r;
        endcase
    end

    // Storage, pointers and registered flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= '0;
            end
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (wrEff_s) begin
                mem_r[wrPtr_r] <= wrData;
                wrPtr_r        <= wrPtr_r + AddrW'(1);
            end
            if (rdEff_s) begin
                rdPtr_r <= rdPtr_r + AddrW'(1);
            end
            count_r <= countNext_s;
            full_r  <= (countNext_s == (AddrW+1)'(Depth));
            empty_r <= (countNext_s == (AddrW+1)'(0));
        end
    end

    assign rdData = mem_r[rdPtr_r];
    assign full   = full_r;
    assign empty  = empty_r;

endmodule

// File: rtl/oclib_uart_core.sv
// oclib_uart_core -- UART with tx/rx FIFOs, configurable framing and sticky rx error flags.
//   clock, reset            : clock, asynchronous active-high reset
//   txData/txValid/txReady  : tx byte stream into the tx FIFO (low DataBits sent, LSB first)
//   rxData/rxValid/rxReady  : rx FIFO head; pop on rxValid && rxReady
//   rx, tx                  : serial lines (rx asynchronous, tx from a flop)
//   rxParityError, rxFramingError, rxOverflow, rxBreak : sticky, cleared by the next pop
// Optional: define OCLIB_UART_LOOPBACK_EN to add input 'loopback' (tx fed to rx, tx pin held 1).
module oclib_uart_core
    import oclib_pkg::*;
#(
    parameter int ClockHz    = 100000000,
    parameter int Baud       = 115200,
    parameter int DataBits   = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1,
    parameter int FifoDepth  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    input  logic       rx,
    output logic       tx,
    output logic       rxParityError,
    output logic       rxFramingError,
    output logic       rxOverflow,
    output logic       rxBreak
`ifdef OCLIB_UART_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int BitCycles = bitCycles(ClockHz, Baud);
    localparam int CntW      = $clog2(StopBits * BitCycles + 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'((BitCycles / 2) - 1);
    localparam logic [CntW-1:0] StopLast = CntW'(StopBits * BitCycles - 1);
    localparam logic [2:0]      DataLast = 3'(DataBits - 1);
    localparam logic [7:0]      DataMask = 8'((1 << DataBits) - 1);
    localparam parityModeE      PMode    = parityModeE'(ParityMode);

    // ---------------- tx side ----------------
    txStateE         txState_r, txStateNext_s;
    logic [CntW-1:0] txCnt_r, txCntNext_s;
    logic [7:0]      txShift_r, txShiftNext_s;
    logic [2:0]      txIdx_r, txIdxNext_s;
    logic            txPar_r, txParNext_s;
    logic            txLine_r, txLineNext_s;
    logic            txPop_s;
    logic [7:0]      txHead_s;
    logic            txFull_s, txEmpty_s;
    logic            resetDone_r;

    // Holds txReady low while in reset and for the release clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) resetDone_r <= 1'b0;
        else       resetDone_r <= 1'b1;
    end

    assign txReady = resetDone_r && !txFull_s;

    oclib_uart_fifo #(.Width(8), .Depth(FifoDepth)) txFifo (
        .clock (clock),
        .reset (reset),
        .wrEn  (txValid && txReady),
        .wrData(txData),
        .rdEn  (txPop_s),
        .rdData(txHead_s),
        .full  (txFull_s),
        .empty (txEmpty_s)
    );

    // Tx next state: a byte is fetched from IDLE or at the end of STOP, so frames run back-to-back.
    always_comb begin
        txStateNext_s = txState_r;
        txCntNext_s   = txCnt_r;
        txShiftNext_s = txShift_r;
        txIdxNext_s   = txIdx_r;
        txParNext_s   = txPar_r;
        txLineNext_s  = txLine_r;
        txPop_s       = 1'b0;
        case (txState_r)
            TX_IDLE: begin
                txLineNext_s = 1'b1;
                if (!txEmpty_s) txPop_s = 1'b1;
                else            txStateNext_s = TX_IDLE;
            end
            TX_START: begin
                if (txCnt_r == BitLast) begin
                    txStateNext_s = TX_DATA;
                    txCntNext_s   = '0;
                    txIdxNext_s   = 3'd0;
                    txLineNext_s  = txShift_r[0];
                end else begin
                    txCntNext_s = txCnt_r + CntW'(1);
                end
            end
            TX_DATA: begin
                if (txCnt_r == BitLast) begin
                    txCntNext_s = '0;
                    if (txIdx_r == DataLast) begin
                        if (PMode == PARITY_NONE) begin
                            txStateNext_s = TX_STOP;
                            txLineNext_s  = 1'b1;
                        end else begin
                            txStateNext_s = TX_PARITY;
                            txLineNext_s  = txPar_r;
                        end
                    end else begin
                        txIdxNext_s  = txIdx_r + 3'd1;
                        txLineNext_s = txShift_r[txIdx_r + 3'd1];
                    end
                end else begin
                    txCntNext_s = txCnt_r + CntW'(1);
                end
            end
            TX_PARITY: begin
                if (txCnt_r == BitLast) begin
                    txStateNext_s = TX_STOP;
                    txCntNext_s   = '0;
                    txLineNext_s  = 1'b1;
                end else begin
                    txCntNext_s = txCnt_r + CntW'(1);
                end
            end
            TX_STOP: begin
                if (txCnt_r == StopLast) begin
                    txCntNext_s = '0;
                    if (!txEmpty_s) begin
                        txPop_s = 1'b1;
                    end else begin
                        txStateNext_s = TX_IDLE;
                        txLineNext_s  = 1'b1;
                    end
                end else begin
                    txCntNext_s = txCnt_r + CntW'(1);
                end
            end
            default: begin
                txStateNext_s = TX_IDLE;
                txLineNext_s  = 1'b1;
            end
        endcase
        // Fetching a byte always starts a new frame with the start bit on the next clock.
        if (txPop_s) begin
            txStateNext_s = TX_START;
            txCntNext_s   = '0;
            txLineNext_s  = 1'b0;
            txShiftNext_s = txHead_s & DataMask;
            txParNext_s   = parityBit(txHead_s & DataMask, PMode);
        end else begin
            txShiftNext_s = txShiftNext_s;
        end
    end

    // Tx state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) txState_r <= TX_IDLE;
        else       txState_r <= txStateNext_s;
    end

    // Tx datapath registers, including the flop that drives the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txCnt_r   <= '0;
            txShift_r <= 8'd0;
            txIdx_r   <= 3'd0;
            txPar_r   <= 1'b0;
            txLine_r  <= 1'b1;
        end else begin
            txCnt_r   <= txCntNext_s;
            txShift_r <= txShiftNext_s;
            txIdx_r   <= txIdxNext_s;
            txPar_r   <= txParNext_s;
            txLine_r  <= txLineNext_s;
        end
    end

    logic rxSrc_s;
`ifdef OCLIB_UART_LOOPBACK_EN
    logic txPin_r;

    // Separate pin flop so the line can be parked high while looping back.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) txPin_r <= 1'b1;
        else       txPin_r <= loopback ? 1'b1 : txLineNext_s;
    end

    assign tx      = txPin_r;
    assign rxSrc_s = loopback ? txLine_r : rx;
`else
    assign tx      = txLine_r;
    assign rxSrc_s = rx;
`endif

    // ---------------- rx side ----------------
    rxStateE         rxState_r, rxStateNext_s;
    logic [CntW-1:0] rxCnt_r, rxCntNext_s;
    logic [7:0]      rxShift_r, rxShiftNext_s;
    logic [2:0]      rxIdx_r, rxIdxNext_s;
    logic            rxZero_r, rxZeroNext_s;
    logic            rxParBad_r, rxParBadNext_s;
    logic            sync1_r, sync2_r, rxLast_r;
    logic            rxPush_s, parSet_s, frameSet_s, breakSet_s, ovfSet_s;
    logic            rxPop_s, rxFull_s, rxEmpty_s;
    logic            rxParErr_r, rxFrameErr_r, rxOvf_r, rxBreak_r;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            rxLast_r <= 1'b1;
        end else begin
            sync1_r  <= rxSrc_s;
            sync2_r  <= sync1_r;
            rxLast_r <= sync2_r;
        end
    end

    // Rx next state; rxZero tracks whether every sample since the start bit was low (break).
    always_comb begin
        rxStateNext_s  = rxState_r;
        rxCntNext_s    = rxCnt_r;
        rxShiftNext_s  = rxShift_r;
        rxIdxNext_s    = rxIdx_r;
        rxZeroNext_s   = rxZero_r;
        rxParBadNext_s = rxParBad_r;
        rxPush_s       = 1'b0;
        parSet_s       = 1'b0;
        frameSet_s     = 1'b0;
        breakSet_s     = 1'b0;
        case (rxState_r)
            RX_IDLE: begin
                if (rxLast_r && !sync2_r) begin
                    rxStateNext_s = RX_START;
                    rxCntNext_s   = '0;
                end else begin
                    rxStateNext_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rxCnt_r == HalfLast) begin
                    rxCntNext_s = '0;
                    if (sync2_r) begin
                        rxStateNext_s = RX_IDLE;
                    end else begin
                        rxStateNext_s  = RX_DATA;
                        rxIdxNext_s    = 3'd0;
                        rxShiftNext_s  = 8'd0;
                        rxZeroNext_s   = 1'b1;
                        rxParBadNext_s = 1'b0;
                    end
                end else begin
                    rxCntNext_s = rxCnt_r + CntW'(1);
                end
            end
            RX_DATA: begin
                if (rxCnt_r == BitLast) begin
                    rxCntNext_s            = '0;
                    rxShiftNext_s[rxIdx_r] = sync2_r;
                    rxZeroNext_s           = rxZero_r && !sync2_r;
                    if (rxIdx_r == DataLast) begin
                        rxStateNext_s = (PMode == PARITY_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        rxIdxNext_s = rxIdx_r + 3'd1;
                    end
                end else begin
                    rxCntNext_s = rxCnt_r + CntW'(1);
                end
            end
            RX_PARITY: begin
                if (rxCnt_r == BitLast) begin
                    rxCntNext_s    = '0;
                    rxParBadNext_s = (sync2_r != parityBit(rxShift_r, PMode));
                    rxZeroNext_s   = rxZero_r && !sync2_r;
                    rxStateNext_s  = RX_STOP;
                end else begin
                    rxCntNext_s = rxCnt_r + CntW'(1);
                end
            end
            RX_STOP: begin
                // Only the first stop bit is sampled; idle detection covers any further stop bits.
                if (rxCnt_r == BitLast) begin
                    rxCntNext_s = '0;
                    if (rxZero_r && !sync2_r) begin
                        breakSet_s    = 1'b1;
                        rxStateNext_s = RX_BREAK;
                    end else begin
                        rxPush_s      = 1'b1;
                        frameSet_s    = !sync2_r;
                        parSet_s      = rxParBad_r;
                        rxStateNext_s = RX_IDLE;
                    end
                end else begin
                    rxCntNext_s = rxCnt_r + CntW'(1);
                end
            end
            RX_BREAK: begin
                if (sync2_r) rxStateNext_s = RX_IDLE;
                else         rxStateNext_s = RX_BREAK;
            end
            default: begin
                rxStateNext_s = RX_IDLE;
            end
        endcase
    end

    // Rx state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rxState_r <= RX_IDLE;
        else       rxState_r <= rxStateNext_s;
    end

    // Rx datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxCnt_r    <= '0;
            rxShift_r  <= 8'd0;
            rxIdx_r    <= 3'd0;
            rxZero_r   <= 1'b0;
            rxParBad_r <= 1'b0;
        end else begin
            rxCnt_r    <= rxCntNext_s;
            rxShift_r  <= rxShiftNext_s;
            rxIdx_r    <= rxIdxNext_s;
            rxZero_r   <= rxZeroNext_s;
            rxParBad_r <= rxParBadNext_s;
        end
    end

    assign rxPop_s  = !rxEmpty_s && rxReady;
    assign ovfSet_s = rxPush_s && rxFull_s && !rxPop_s;

    oclib_uart_fifo #(.Width(8), .Depth(FifoDepth)) rxFifo (
        .clock (clock),
        .reset (reset),
        .wrEn  (rxPush_s),
        .wrData(rxShift_r),
        .rdEn  (rxPop_s),
        .rdData(rxData),
        .full  (rxFull_s),
        .empty (rxEmpty_s)
    );

    // Sticky error flags: a new event wins over a same-clock pop clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxParErr_r   <= 1'b0;
            rxFrameErr_r <= 1'b0;
            rxOvf_r      <= 1'b0;
            rxBreak_r    <= 1'b0;
        end else begin
            if (parSet_s)        rxParErr_r   <= 1'b1;
            else if (rxPop_s)    rxParErr_r   <= 1'b0;
            if (frameSet_s)      rxFrameErr_r <= 1'b1;
            else if (rxPop_s)    rxFrameErr_r <= 1'b0;
            if (ovfSet_s)        rxOvf_r      <= 1'b1;
            else if (rxPop_s)    rxOvf_r      <= 1'b0;
            if (breakSet_s)      rxBreak_r    <= 1'b1;
            else if (rxPop_s)    rxBreak_r    <= 1'b0;
        end
    end

    assign rxValid        = !rxEmpty_s;
    assign rxParityError  = rxParErr_r;
    assign rxFramingError = rxFrameErr_r;
    assign rxOverflow     = rxOvf_r;
    assign rxBreak        = rxBreak_r;

endmodule

// File: tb/tb_oclib_uart_core.sv
// Bench for oclib_uart_core: instance A is 8N1, instance B is 8E2; both at 10 clocks per bit.
module tb_oclib_uart_core;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0] txDataA, rxDataA, txDataB, rxDataB;
    logic txValidA, txReadyA, rxValidA, rxReadyA, rxA, txA;
    logic perA, ferA, ovfA, brkA;
    logic txValidB, txReadyB, rxValidB, rxReadyB, rxB, txB;
    logic perB, ferB, ovfB, brkB;

    oclib_uart_core #(.ClockHz(100000000), .Baud(10000000), .DataBits(8), .ParityMode(0),
                      .StopBits(1), .FifoDepth(16)) dutA (
        .clock(clock), .reset(reset), .txData(txDataA), .txValid(txValidA), .txReady(txReadyA),
        .rxData(rxDataA), .rxValid(rxValidA), .rxReady(rxReadyA), .rx(rxA), .tx(txA),
        .rxParityError(perA), .rxFramingError(ferA), .rxOverflow(ovfA), .rxBreak(brkA)
`ifdef OCLIB_UART_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    oclib_uart_core #(.ClockHz(100000000), .Baud(10000000), .DataBits(8), .ParityMode(2),
                      .StopBits(2), .FifoDepth(16)) dutB (
        .clock(clock), .reset(reset), .txData(txDataB), .txValid(txValidB), .txReady(txReadyB),
        .rxData(rxDataB), .rxValid(rxValidB), .rxReady(rxReadyB), .rx(rxB), .tx(txB),
        .rxParityError(perB), .rxFramingError(ferB), .rxOverflow(ovfB), .rxBreak(brkB)
`ifdef OCLIB_UART_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference serialiser: one sample per clock, 10 clocks per bit, frame starts at bit 0.
    function automatic logic [255:0] frameWave(input logic [7:0] d, input int pm, input int sb,
                                               input bit flipPar);
        bit bits[$];
        logic [255:0] w;
        int ones;
        bit p;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pm != 0) begin
            ones = $countones(d);
            p = (pm == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            bits.push_back(p ^ flipPar);
        end
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        w = '0;
        foreach (bits[j]) for (int k = 0; k < 10; k++) w[j*10+k] = bits[j];
        return w;
    endfunction

    // Reference receiver: mid-bit sampling of a captured waveform.
    function automatic logic [7:0] decode(input logic [255:0] w);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = w[10*(i+1)+5];
        return d;
    endfunction

    task automatic writeTx(input bit useB, input logic [7:0] d);
        @(negedge clock);
        if (useB) begin txDataB = d; txValidB = 1'b1; end
        else      begin txDataA = d; txValidA = 1'b1; end
        @(posedge clock); #1;
        txValidA = 1'b0; txValidB = 1'b0;
    endtask

    task automatic writeTx2(input bit useB, input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clock);
        if (useB) begin txDataB = d0; txValidB = 1'b1; end
        else      begin txDataA = d0; txValidA = 1'b1; end
        @(posedge clock); #1;
        if (useB) txDataB = d1; else txDataA = d1;
        @(posedge clock); #1;
        txValidA = 1'b0; txValidB = 1'b0;
    endtask

    task automatic captureTx(input bit useB, input int nClk, output logic [255:0] w, output bit found);
        found = 1'b0;
        w = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if ((useB ? txB : txA) == 1'b0) found = 1'b1;
        end
        if (found) begin
            for (int i = 1; i < nClk; i++) begin
                @(negedge clock);
                w[i] = useB ? txB : txA;
            end
        end
    endtask

    task automatic sendRx(input bit useB, input logic [7:0] d, input int pm, input int sb, input bit flipPar);
        logic [255:0] w;
        int n;
        w = frameWave(d, pm, sb, flipPar);
        n = (9 + ((pm != 0) ? 1 : 0) + sb) * 10;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (useB) rxB = w[i]; else rxA = w[i];
        end
    endtask

    task automatic waitRxValid(input bit useB, input int maxClk, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxClk && !found; i++) begin
            @(negedge clock);
            if (useB ? rxValidB : rxValidA) found = 1'b1;
        end
    endtask

    task automatic pop(input bit useB);
        @(negedge clock);
        if (useB) rxReadyB = 1'b1; else rxReadyA = 1'b1;
        @(negedge clock);
        rxReadyA = 1'b0; rxReadyB = 1'b0;
    endtask

    initial begin
        logic [255:0] w;
        logic [255:0] exp;
        logic [7:0]   d;
        logic [7:0]   q[$];
        bit           found;
        int           lowCnt, validCnt;

        reset = 1'b1;
        txDataA = 8'd0; txValidA = 1'b0; rxReadyA = 1'b0; rxA = 1'b1;
        txDataB = 8'd0; txValidB = 1'b0; rxReadyB = 1'b0; rxB = 1'b1;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_txA", txA, 1'b1);
        chk("rst_txReadyA", txReadyA, 1'b0);
        chk("rst_rxValidA", rxValidA, 1'b0);
        chk("rst_rxDataA", rxDataA, 8'h00);
        chk("rst_flagsA", {perA, ferA, ovfA, brkA}, 4'h0);
        chk("rst_txB", txB, 1'b1);
        chk("rst_txReadyB", txReadyB, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_txReadyA", txReadyA, 1'b1);

        // 0x55 in 8N1
        writeTx(1'b0, 8'h55);
        captureTx(1'b0, 100, w, found);
        chk("tx55_start", found, 1'b1);
        chk("tx55_wave", w, frameWave(8'h55, 0, 1, 1'b0));
        chk("tx55_model", decode(w), 8'h55);

        // Random tx bytes
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            writeTx(1'b0, d);
            captureTx(1'b0, 100, w, found);
            chk("txRand_wave", w, frameWave(d, 0, 1, 1'b0));
            chk("txRand_model", decode(w), d);
        end

        // Back-to-back 8E2 frames 0x00, 0xFF
        writeTx2(1'b1, 8'h00, 8'hFF);
        captureTx(1'b1, 240, w, found);
        exp = frameWave(8'h00, 2, 2, 1'b0) | (frameWave(8'hFF, 2, 2, 1'b0) << 120);
        chk("b2b_start", found, 1'b1);
        chk("b2b_wave", w, exp);
        chk("b2b_stopGap", w[119:100], 20'hFFFFF);
        @(negedge clock);
        chk("b2b_idleAfter", txB, 1'b1);

        // 0xA3 with wrong even parity
        sendRx(1'b1, 8'hA3, 2, 2, 1'b1);
        waitRxValid(1'b1, 40, found);
        chk("par_valid", found, 1'b1);
        chk("par_data", rxDataB, 8'hA3);
        chk("par_err", perB, 1'b1);
        chk("par_noFrameErr", ferB, 1'b0);
        pop(1'b1);
        chk("par_errCleared", perB, 1'b0);
        chk("par_emptyAfterPop", rxValidB, 1'b0);

        // 17 random bytes into a 16-deep rx FIFO
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            sendRx(1'b0, d, 0, 1, 1'b0);
        end
        repeat (20) @(negedge clock);
        chk("ovf_flag", ovfA, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_valid", rxValidA, 1'b1);
            chk("ovf_order", rxDataA, q[i]);
            pop(1'b0);
            if (i == 0) chk("ovf_clearedByPop", ovfA, 1'b0);
        end
        chk("ovf_17thDropped", rxValidA, 1'b0);

        // 3-clock glitch
        @(negedge clock); rxA = 1'b0;
        repeat (3) @(negedge clock);
        rxA = 1'b1;
        repeat (40) @(negedge clock);
        chk("glitch_noByte", rxValidA, 1'b0);
        chk("glitch_noFlags", {perA, ferA, ovfA, brkA}, 4'h0);

        // Break: 20 bit times low
        rxA = 1'b0;
        repeat (200) @(negedge clock);
        rxA = 1'b1;
        repeat (20) @(negedge clock);
        chk("brk_flag", brkA, 1'b1);
        chk("brk_notPushed", rxValidA, 1'b0);
        d = 8'($urandom);
        sendRx(1'b0, d, 0, 1, 1'b0);
        waitRxValid(1'b0, 40, found);
        chk("brk_recoverValid", found, 1'b1);
        chk("brk_recoverData", rxDataA, d);
        pop(1'b0);
        chk("brk_clearedByPop", brkA, 1'b0);

        // Reset mid-byte on tx and rx
        writeTx2(1'b0, 8'($urandom), 8'($urandom));
        repeat (30) @(negedge clock);
        rxA = 1'b0;
        repeat (25) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rstMid_tx", txA, 1'b1);
        chk("rstMid_txReady", txReadyA, 1'b0);
        chk("rstMid_rxValid", rxValidA, 1'b0);
        rxA = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        lowCnt = 0;
        validCnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (txA == 1'b0) lowCnt++;
            if (rxValidA) validCnt++;
        end
        chk("rstMid_txStaysIdle", lowCnt, 0);
        chk("rstMid_noStrayByte", validCnt, 0);
        chk("rstMid_txReadyBack", txReadyA, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
